// File: rtl/weight_loader.sv
// weight_loader: packs a serial stream of weight words into full memory rows.
// LANES consecutive accepted words form one row, written to addresses
// 0..DEPTH-1 in order. A single-cycle done pulse follows the final row write.
module weight_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 32,
    parameter int DEPTH      = 100,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [DATA_WIDTH*LANES-1:0]   wr_data,
    output logic                          busy,
    output logic                          done
);

    localparam int ROW_WIDTH  = DATA_WIDTH * LANES;
    localparam int LANE_WIDTH = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(LANES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_t;

    state_t                 state;
    logic [LANE_WIDTH-1:0]  lane;
    logic [ADDR_WIDTH-1:0]  row;
    logic [ROW_WIDTH-1:0]   pack;
    logic [ROW_WIDTH-1:0]   row_next;
    logic                   accept;

    // A word moves only when the registered ready meets a valid word.
    assign accept = in_valid && in_ready;

    // Pack register with the incoming word dropped into the current lane.
    always_comb begin
        row_next = pack;
        row_next[int'(lane) * DATA_WIDTH +: DATA_WIDTH] = in_data;
    end

    // Control FSM; every output is registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lane     <= '0;
            row      <= '0;
            pack     <= '0;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only here; the defaults below are
            // overridden later in the same block, and the last write wins.
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FILL;
                        lane     <= '0;
                        row      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                FILL: begin
                    if (abort) begin
                        // Abort outranks any word offered in the same cycle,
                        // so a partial row is never written.
                        state    <= IDLE;
                        lane     <= '0;
                        row      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end else if (accept) begin
                        pack <= row_next;
                        if (lane == LAST_LANE) begin
                            // Drop ready for the write cycle so no word can
                            // arrive while the row is being stored.
                            state    <= WRITE;
                            lane     <= '0;
                            in_ready <= 1'b0;
                            wr_en    <= 1'b1;
                            wr_addr  <= row;
                            wr_data  <= row_next;
                        end else begin
                            lane <= lane + LANE_WIDTH'(1);
                        end
                    end
                end
                WRITE: begin
                    if (abort) begin
                        // The strobe of this cycle has already gone out.
                        state <= IDLE;
                        lane  <= '0;
                        row   <= '0;
                        busy  <= 1'b0;
                    end else if (row == LAST_ROW) begin
                        state <= IDLE;
                        row   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= FILL;
                        row      <= row + ADDR_WIDTH'(1);
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    lane     <= '0;
                    row      <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Testbench for weight_loader: a control-vector table for the start/abort
// rules, then full loads (steady and gappy stream) scored against a model
// that chunks the accepted-word list into rows, plus abort and reset cases.
module tb_weight_loader;

    localparam int DW    = 16;
    localparam int LANES = 32;
    localparam int DEPTH = 100;
    localparam int AW    = 8;
    localparam int ROW_W = DW * LANES;
    localparam int TOTAL = DEPTH * LANES;

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [ROW_W-1:0]  wr_data;
    logic              busy;
    logic              done;

    weight_loader #(
        .DATA_WIDTH (DW),
        .LANES      (LANES),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: every accepted word in order; row r is words r*LANES..
    logic [DW-1:0]    acc_q[$];
    int               n_writes;
    int               n_done;
    int               cyc;
    int               last_wr_cyc;
    int               done_cyc;
    logic [ROW_W-1:0] first_row;
    logic [ROW_W-1:0] last_row;

    typedef struct {
        logic start;
        logic abort;
        logic valid;
        logic exp_ready;
        logic exp_busy;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [ROW_W-1:0] act,
                         input logic [ROW_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_model();
        acc_q.delete();
        n_writes    = 0;
        n_done      = 0;
        last_wr_cyc = -100;
        done_cyc    = -100;
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic tick(output bit xfer);
        logic [ROW_W-1:0] exp_row;
        int base;
        @(negedge clk);
        cyc++;
        xfer = in_valid && in_ready;
        if (xfer) acc_q.push_back(in_data);
        if (wr_en) begin
            base    = n_writes * LANES;
            exp_row = '0;
            for (int k = 0; k < LANES; k++)
                if (base + k < acc_q.size()) exp_row[k*DW +: DW] = acc_q[base + k];
            check("ready_low_in_write", in_ready, 1'b0);
            check("done_with_wr_en", done, 1'b0);
            check("row_complete", acc_q.size() >= base + LANES, 1'b1);
            check("wr_addr", wr_addr, n_writes);
            check("wr_data", wr_data, exp_row);
            if (n_writes == 0) first_row = wr_data;
            last_row    = wr_data;
            last_wr_cyc = cyc;
            n_writes++;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ticks(input int n);
        bit x;
        for (int i = 0; i < n; i++) tick(x);
    endtask

    task automatic start_pulse();
        bit x;
        start = 1'b1;
        tick(x);
        start = 1'b0;
    endtask

    // Stream words 0..n-1; optional random gaps and a start pulse at word start_at.
    task automatic stream(input int n, input bit gaps, input int start_at);
        int idx = 0;
        int budget = n * 4 + 200;
        bit x;
        bit pulsed = 1'b0;
        while (idx < n && budget > 0) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = DW'(idx);
            start    = (idx == start_at) && !pulsed;
            if (start) pulsed = 1'b1;
            tick(x);
            start = 1'b0;
            if (x) idx++;
            budget--;
        end
        in_valid = 1'b0;
        check("stream_complete", idx, n);
    endtask

    task automatic finish_load(input string tag);
        idle_ticks(5);
        check({tag, "_writes"}, n_writes, DEPTH);
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_done_after_last_write"}, done_cyc, last_wr_cyc + 1);
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_ready_after"}, in_ready, 1'b0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_wr_en"}, wr_en, 1'b0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        cyc      = 0;
        clear_model();
        idle_ticks(3);
        reset = 1'b0;
        check_cleared("reset");

        // Control vectors: expected ready/busy just after the edge that sees them.
        vecs[0] = '{start: 1'b0, abort: 1'b1, valid: 1'b0, exp_ready: 1'b0, exp_busy: 1'b0};
        vecs[1] = '{start: 1'b1, abort: 1'b1, valid: 1'b0, exp_ready: 1'b1, exp_busy: 1'b1};
        vecs[2] = '{start: 1'b0, abort: 1'b0, valid: 1'b0, exp_ready: 1'b1, exp_busy: 1'b1};
        vecs[3] = '{start: 1'b0, abort: 1'b0, valid: 1'b1, exp_ready: 1'b1, exp_busy: 1'b1};
        vecs[4] = '{start: 1'b1, abort: 1'b0, valid: 1'b1, exp_ready: 1'b1, exp_busy: 1'b1};
        vecs[5] = '{start: 1'b0, abort: 1'b0, valid: 1'b0, exp_ready: 1'b1, exp_busy: 1'b1};
        vecs[6] = '{start: 1'b1, abort: 1'b1, valid: 1'b0, exp_ready: 1'b0, exp_busy: 1'b0};
        vecs[7] = '{start: 1'b0, abort: 1'b0, valid: 1'b1, exp_ready: 1'b0, exp_busy: 1'b0};
        vecs[8] = '{start: 1'b1, abort: 1'b0, valid: 1'b0, exp_ready: 1'b1, exp_busy: 1'b1};
        vecs[9] = '{start: 1'b0, abort: 1'b1, valid: 1'b0, exp_ready: 1'b0, exp_busy: 1'b0};
        for (int i = 0; i < 10; i++) begin
            bit x;
            start    = vecs[i].start;
            abort    = vecs[i].abort;
            in_valid = vecs[i].valid;
            in_data  = DW'(16'hA500 + i);
            tick(x);
            check($sformatf("vec%0d_ready", i), in_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d_wr_en", i), wr_en, 1'b0);
            check($sformatf("vec%0d_done", i), done, 1'b0);
        end
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        idle_ticks(2);

        // Full load, steady stream; row r lane k must hold r*LANES+k.
        clear_model();
        start_pulse();
        stream(TOTAL, 1'b0, -1);
        finish_load("full");
        check("row0_lane0", first_row[15:0], 16'h0000);
        check("row0_lane31", first_row[511:496], 16'h001F);
        check("row99_lane31", last_row[511:496], 16'h0C7F);
        check("row99_lane0", last_row[15:0], 16'h0C60);

        // Words offered after completion are refused.
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        idle_ticks(3);
        check("no_accept_after_done", acc_q.size(), TOTAL);
        check("ready_low_after_done", in_ready, 1'b0);
        in_valid = 1'b0;

        // Backpressure: ~50% valid duty.
        clear_model();
        start_pulse();
        stream(TOTAL, 1'b1, -1);
        finish_load("gappy");
        check("gappy_accepted", acc_q.size(), TOTAL);

        // Start pulse while filling row 3 is ignored.
        clear_model();
        start_pulse();
        stream(TOTAL, 1'b1, 3 * LANES + 8);
        finish_load("start_busy");

        // Abort after 10 words of row 5.
        clear_model();
        start_pulse();
        stream(5 * LANES + 10, 1'b0, -1);
        abort = 1'b1;
        idle_ticks(1);
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_ready", in_ready, 1'b0);
        in_valid = 1'b1;
        idle_ticks(5);
        in_valid = 1'b0;
        check("abort_writes", n_writes, 5);
        check("abort_no_done", n_done, 0);
        clear_model();
        start_pulse();
        stream(TOTAL, 1'b0, -1);
        finish_load("after_abort");

        // Asynchronous reset during row 50.
        clear_model();
        start_pulse();
        stream(50 * LANES + 5, 1'b0, -1);
        check("pre_reset_busy", busy, 1'b1);
        #2 reset = 1'b1;
        #1 check_cleared("async_reset");
        in_valid = 1'b1;
        idle_ticks(3);
        in_valid = 1'b0;
        check("reset_writes", n_writes, 50);
        #2 reset = 1'b0;
        clear_model();
        start_pulse();
        stream(TOTAL, 1'b0, -1);
        finish_load("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
